response_framer: RTL and testbench

Buffers sensor responses from the sensor decoder and serialises each into a two-byte UART frame (response code, then data byte). Sits between the sensor decoder and the UART transmitter in the DigitalSensor datapath. Absorbs back-to-back responses while the transmitter is busy, and recovers from a stalled transmitter with a watchdog.

---
 rtl/response_framer_pkg.sv | 16 +
 rtl/response_fifo.sv | 53 +++++
 rtl/response_framer.sv | 129 ++++++++++++
 tb/tb_response_framer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/response_framer_pkg.sv
// Shared types and constants for the response framer: FSM state encoding,
// FIFO entry width and the default per-byte transmit watchdog limit.
package response_framer_pkg;

    localparam int ENTRY_W            = 16;
    localparam int DEFAULT_TX_TIMEOUT = 50000;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CODE,
        WAIT_CODE,
        SEND_DATA,
        WAIT_DATA
    } response_framer_state_t;

endpackage

// File: rtl/response_fifo.sv
// Circular-buffer FIFO with head peek; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module response_fifo
    import response_framer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             peek,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign peek    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/response_framer.sv
// Queues sensor responses and sends each as a two-byte UART frame (code, data),
// aborting a frame when the transmitter stalls longer than TX_TIMEOUT per byte.
module response_framer
    import response_framer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int TX_TIMEOUT = DEFAULT_TX_TIMEOUT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       has_response,
    input  logic [7:0] response_code,
    input  logic [7:0] response_data,
    input  logic       is_transmitting,
    input  logic       transmission_done,
    output logic       has_data,
    output logic [7:0] data_to_send,
    output logic       fifo_full,
    output logic       overflow,
    output logic       tx_error,
    output logic       busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WD_W  = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TX_TIMEOUT - 1);

    response_framer_state_t state, state_next;

    logic [ENTRY_W-1:0] head;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               pop_req;
    logic [WD_W-1:0]    wd;
    logic               wd_clear;
    logic               has_data_next;
    logic [7:0]         data_next;
    logic               tx_error_next;
    logic               overflow_next;

    response_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (has_response),
        .pop       (pop_req),
        .push_data ({response_code, response_data}),
        .peek      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy = (state != IDLE) || (fifo_count != '0);

    // A done in the same cycle as the watchdog limit wins over the timeout.
    always_comb begin
        state_next    = state;
        has_data_next = 1'b0;
        data_next     = data_to_send;
        pop_req       = 1'b0;
        tx_error_next = 1'b0;
        wd_clear      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !is_transmitting) state_next = SEND_CODE;
            end
            SEND_CODE: begin
                has_data_next = 1'b1;
                data_next     = head[ENTRY_W-1 -: 8];
                wd_clear      = 1'b1;
                state_next    = WAIT_CODE;
            end
            WAIT_CODE: begin
                if (transmission_done) begin
                    state_next = SEND_DATA;
                end else if (wd == WD_LAST) begin
                    pop_req       = 1'b1;
                    tx_error_next = 1'b1;
                    state_next    = IDLE;
                end
            end
            SEND_DATA: begin
                if (!is_transmitting) begin
                    has_data_next = 1'b1;
                    data_next     = head[7:0];
                    wd_clear      = 1'b1;
                    state_next    = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (transmission_done) begin
                    pop_req    = 1'b1;
                    state_next = IDLE;
                end else if (wd == WD_LAST) begin
                    pop_req       = 1'b1;
                    tx_error_next = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        overflow_next = has_response && fifo_full && !pop_req;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wd           <= '0;
            has_data     <= 1'b0;
            data_to_send <= 8'h00;
            overflow     <= 1'b0;
            tx_error     <= 1'b0;
        end else begin
            state        <= state_next;
            has_data     <= has_data_next;
            data_to_send <= data_next;
            overflow     <= overflow_next;
            tx_error     <= tx_error_next;
            if (wd_clear)
                wd <= '0;
            else if (state == WAIT_CODE || state == WAIT_DATA)
                wd <= wd + WD_W'(1);
        end
    end

endmodule

// File: tb/tb_response_framer.sv
// Randomised bench for response_framer: a queue-based model of accepted responses
// plus a behavioural UART transmitter predict every byte, flag and watchdog abort.
module tb_response_framer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       has_response;
    logic [7:0] response_code;
    logic [7:0] response_data;
    logic       is_transmitting;
    logic       transmission_done;
    logic       has_data;
    logic [7:0] data_to_send;
    logic       fifo_full;
    logic       overflow;
    logic       tx_error;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] model_q[$];
    int   cyc, mode, l_fixed, l_target, age, hold_cnt;
    int   strobe_count, first_strobe, first_tx_error;
    bit   in_flight, in_idx, next_byte, force_done, prev_tx, prev_has_data;
    logic [7:0] last_byte;

    always #5 clock = ~clock;

    response_framer #(
        .DEPTH      (DEPTH),
        .TX_TIMEOUT (TIMEOUT)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .has_response      (has_response),
        .response_code     (response_code),
        .response_data     (response_data),
        .is_transmitting   (is_transmitting),
        .transmission_done (transmission_done),
        .has_data          (has_data),
        .data_to_send      (data_to_send),
        .fifo_full         (fifo_full),
        .overflow          (overflow),
        .tx_error          (tx_error),
        .busy              (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // One clock cycle: mode 0 = responsive transmitter, 1 = stalled busy, 2 = never done.
    task automatic applyStimulus(input bit push, input logic [15:0] value);
        bit done_now, timeout_now, pop_now, exp_ovf;
        logic [7:0] exp_byte;
        done_now    = 1'b0;
        timeout_now = 1'b0;
        if (in_flight) begin
            if (mode == 0 && age == l_target) done_now = 1'b1;
            else if (age == TIMEOUT - 1)      timeout_now = 1'b1;
        end
        pop_now = (done_now && in_idx) || timeout_now;
        exp_ovf = push && (model_q.size() == DEPTH) && !pop_now;

        has_response      = push;
        response_code     = value[15:8];
        response_data     = value[7:0];
        transmission_done = done_now || force_done;
        case (mode)
            1:       is_transmitting = 1'b1;
            2:       is_transmitting = 1'b0;
            default: is_transmitting = in_flight || (hold_cnt > 0);
        endcase

        @(posedge clock);
        prev_tx = is_transmitting;
        if (pop_now) void'(model_q.pop_front());
        if (push && !exp_ovf) model_q.push_back(value);
        if (!in_flight && hold_cnt > 0) hold_cnt--;
        if (in_flight) age++;
        if (done_now) begin
            in_flight = 1'b0;
            hold_cnt  = (l_fixed < 0) ? int'($urandom_range(0, 3)) : 0;
        end
        if (timeout_now) begin
            in_flight = 1'b0;
            next_byte = 1'b0;
        end

        @(negedge clock);
        has_response      = 1'b0;
        transmission_done = 1'b0;
        cyc++;

        checkOutput("overflow", overflow, exp_ovf);
        checkOutput("tx_error", tx_error, timeout_now);
        checkOutput("fifo_full", fifo_full, model_q.size() == DEPTH);
        checkOutput("busy", busy, model_q.size() != 0);
        if (has_data) begin
            strobe_count++;
            if (first_strobe < 0) first_strobe = cyc;
            checkOutput("strobe_back_to_back", prev_has_data, 0);
            checkOutput("strobe_while_tx_busy", prev_tx, 0);
            checkOutput("strobe_overlap", in_flight, 0);
            if (model_q.size() == 0) begin
                checkOutput("strobe_with_empty_fifo", 1, 0);
                exp_byte = 8'h00;
            end else begin
                exp_byte = next_byte ? model_q[0][7:0] : model_q[0][15:8];
                if (next_byte) checkOutput("data_byte", data_to_send, exp_byte);
                else           checkOutput("code_byte", data_to_send, exp_byte);
            end
            last_byte = exp_byte;
            in_flight = 1'b1;
            in_idx    = next_byte;
            next_byte = ~next_byte;
            age       = 0;
            if (l_fixed >= 0)                   l_target = l_fixed;
            else if ($urandom_range(0, 7) == 0) l_target = int'($urandom_range(TIMEOUT - 1, TIMEOUT));
            else                                l_target = int'($urandom_range(0, 8));
        end else if (in_flight) begin
            checkOutput("data_held", data_to_send, last_byte);
        end
        if (tx_error && first_tx_error < 0) first_tx_error = cyc;
        prev_has_data = has_data;
    endtask

    task automatic drainQueue(input int limit);
        int n;
        n = 0;
        while ((model_q.size() != 0 || in_flight || busy) && n < limit) begin
            applyStimulus(1'b0, 16'h0000);
            n++;
        end
        checkOutput("drain_within_bound", n < limit, 1);
    endtask

    task automatic waitDataInFlight(input int limit);
        int n;
        n = 0;
        while (!(in_flight && in_idx && age == l_target) && n < limit) begin
            applyStimulus(1'b0, 16'h0000);
            n++;
        end
        checkOutput("reach_wait_data", n < limit, 1);
    endtask

    initial begin
        int c0, s0;
        reset = 1'b1;
        has_response = 1'b0; response_code = 8'h00; response_data = 8'h00;
        is_transmitting = 1'b0; transmission_done = 1'b0;
        cyc = 0; mode = 0; l_fixed = -1; l_target = 0; age = 0; hold_cnt = 0;
        strobe_count = 0; first_strobe = -1; first_tx_error = -1;
        in_flight = 0; in_idx = 0; next_byte = 0; force_done = 0;
        prev_tx = 0; prev_has_data = 0; last_byte = 8'h00;

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_has_data", has_data, 0);
        checkOutput("reset_data_to_send", data_to_send, 8'h00);
        checkOutput("reset_fifo_full", fifo_full, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_tx_error", tx_error, 0);
        checkOutput("reset_busy", busy, 0);
        reset = 1'b0;

        // Single response, transmitter done 10 cycles after each strobe.
        l_fixed = 10;
        c0 = cyc; s0 = strobe_count; first_strobe = -1;
        applyStimulus(1'b1, 16'hA13C);
        drainQueue(100);
        checkOutput("single_latency", first_strobe, c0 + 3);
        checkOutput("single_strobes", strobe_count - s0, 2);

        // Stray done while idle: empty, then with an entry held back by a busy transmitter.
        force_done = 1'b1;
        applyStimulus(1'b0, 16'h0000);
        force_done = 1'b0;
        checkOutput("stray_idle_busy", busy, 0);
        mode = 1;
        applyStimulus(1'b1, 16'h7788);
        force_done = 1'b1;
        applyStimulus(1'b0, 16'h0000);
        force_done = 1'b0;
        checkOutput("stray_no_pop", busy, 1);
        mode = 0; l_fixed = -1; s0 = strobe_count;
        drainQueue(200);
        checkOutput("stray_entry_sent", strobe_count - s0, 2);

        // Burst of five into a stalled transmitter.
        mode = 1;
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, {8'(i * 17), 8'(i)});
        checkOutput("burst_overflow", overflow, 1);
        checkOutput("burst_full", fifo_full, 1);
        mode = 0; s0 = strobe_count;
        drainQueue(400);
        checkOutput("burst_strobes", strobe_count - s0, 8);

        // Push coinciding with the data-byte done while full.
        mode = 1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, {8'hB0 + 8'(i), 8'h40 + 8'(i)});
        mode = 0; l_fixed = 3;
        waitDataInFlight(200);
        applyStimulus(1'b1, 16'hEE99);
        checkOutput("push_pop_full_no_overflow", overflow, 0);
        checkOutput("push_pop_full_count", fifo_full, 1);
        l_fixed = -1;
        drainQueue(400);

        // Watchdog: transmitter never completes a byte.
        mode = 2; first_strobe = -1; first_tx_error = -1;
        applyStimulus(1'b1, 16'hC1D1);
        applyStimulus(1'b1, 16'hC2D2);
        drainQueue(200);
        checkOutput("watchdog_delay", first_tx_error - first_strobe, TIMEOUT);
        mode = 0;

        // Reset during WAIT_DATA with two entries queued behind the head.
        mode = 1;
        applyStimulus(1'b1, 16'h5A11);
        applyStimulus(1'b1, 16'h6B22);
        applyStimulus(1'b1, 16'h7C33);
        mode = 0; l_fixed = 6;
        waitDataInFlight(200);
        checkOutput("pre_reset_depth", model_q.size(), 3);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_has_data", has_data, 0);
        checkOutput("midreset_data_to_send", data_to_send, 8'h00);
        checkOutput("midreset_fifo_full", fifo_full, 0);
        checkOutput("midreset_overflow", overflow, 0);
        checkOutput("midreset_tx_error", tx_error, 0);
        checkOutput("midreset_busy", busy, 0);
        is_transmitting = 1'b0;
        @(posedge clock);
        @(negedge clock);
        model_q.delete();
        in_flight = 0; next_byte = 0; hold_cnt = 0; prev_tx = 0; prev_has_data = 0;
        reset = 1'b0;
        l_fixed = -1; s0 = strobe_count;
        repeat (25) applyStimulus(1'b0, 16'h0000);
        checkOutput("post_reset_silent", strobe_count - s0, 0);

        // Randomised traffic with random byte latencies, including at the watchdog limit.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 35) applyStimulus(1'b1, 16'($urandom));
            else                            applyStimulus(1'b0, 16'h0000);
        end
        drainQueue(1500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
